mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 64, meaning data and address width in bits.
REQ-002 SHALL have parameter REG_COUNT, default 32, meaning register file entries; rd width is $clog2(REG_COUNT).
REQ-003 SHALL have parameter WB_Ctrl_bits, default 5, meaning writeback control field width.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-005 SHALL have inputs from EX/MEM: valid_in 1; mem_read 1; mem_write 1; funct3 3 size/sign; ALU_res_in REG_WIDTH (result/address); store_data REG_WIDTH; rd_addr_in $clog2(REG_COUNT); WB_Ctrl_in WB_Ctrl_bits.
REQ-006 SHALL have data memory ports: dmem_req out 1; dmem_we out 1; dmem_addr out REG_WIDTH; dmem_wdata out 64; dmem_wstrb out 8; dmem_ready in 1; dmem_rdata in 64.
REQ-007 SHALL have outputs to MEM/WB: valid_out 1; WB_Ctrl_out WB_Ctrl_bits; mem_read_data_out REG_WIDTH; ALU_res_out REG_WIDTH; rd_addr_out $clog2(REG_COUNT); mem_exc 1; stall_out 1 (freezes IF..EX/MEM).

Function
REQ-008 SHALL use FSM states IDLE, REQ, DONE.
REQ-009 IDLE, valid_in=1, mem_read=mem_write=0: pass WB_Ctrl_in, ALU_res_in, rd_addr_in combinationally; valid_out=1, mem_read_data_out=0, stall_out=0, stay IDLE.
REQ-010 IDLE, valid_in=0: valid_out=0, WB_Ctrl_out=0, stall_out=0.
REQ-011 Access size per funct3: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 illegal.
REQ-012 Access is faulting if funct3=111, if mem_read and mem_write both 1, or if address is not naturally aligned (H: addr[0]=0; W: addr[1:0]=0; D: addr[2:0]=0).
REQ-013 IDLE, valid_in=1, memory op, faulting: no dmem request; valid_out=1, mem_exc=1, WB_Ctrl_out=0, stall_out=0, stay IDLE.
REQ-014 IDLE, valid_in=1, memory op, not faulting: stall_out=1 combinationally; latch op, funct3, address, store data, rd, WB_Ctrl; go REQ at next edge.
REQ-015 REQ: dmem_req=1, stall_out=1; dmem_addr={addr[REG_WIDTH-1:3],3'b000}; dmem_we=mem_write; all held stable until dmem_ready=1.
REQ-016 Store: dmem_wstrb has lanes addr[2:0]..addr[2:0]+size-1 set; dmem_wdata = store_data low size bytes shifted left by 8*addr[2:0]; dmem_wstrb=0 for loads.
REQ-017 REQ with dmem_ready=1: loads capture dmem_rdata shifted right by 8*addr[2:0], truncated to size, sign-extended (B/H/W) or zero-extended (BU/HU/WU/D), into a data register; go DONE.
REQ-018 DONE (exactly one cycle): dmem_req=0, stall_out=0, valid_out=1, mem_exc=0, outputs from latched values; mem_read_data_out=captured data for loads, 0 for stores; go IDLE.
REQ-019 Minimum stall for an accepted access SHALL be 2 cycles (IDLE accept, REQ with ready); each cycle dmem_ready is low adds one.
REQ-020 Inputs SHALL be ignored in REQ and DONE; upstream holds them under stall_out.
REQ-021 mem_exc SHALL be 0 whenever valid_out=0.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE and clear all latched registers; dmem_req=0, dmem_we=0, dmem_wstrb=0, stall_out=0.
REQ-023 rst asserted in REQ SHALL abandon the access; no DONE cycle and no valid_out for it after release.

Verification
REQ-024 LB addr 0x1003, dmem_rdata 0x1122334485667788, ready in first REQ cycle -> stall_out 2 cycles, then mem_read_data_out 0xFFFFFFFFFFFFFF85, valid_out=1 one cycle.
REQ-025 Same as REQ-024 with LBU -> mem_read_data_out 0x0000000000000085; ALU_res_out 0x1003, rd and WB_Ctrl passed.
REQ-026 SH addr 0x2006, store_data 0xABCD -> dmem_addr 0x2000, dmem_wstrb 0xC0, dmem_wdata[63:48]=0xABCD, dmem_we=1.
REQ-027 LW addr 0x3002 -> no dmem_req, mem_exc=1, WB_Ctrl_out=0, stall_out=0, same cycle.
REQ-028 LD addr 0x4000, dmem_ready held low 3 REQ cycles -> stall_out 5 cycles total, dmem_addr stable throughout, data returned as-is.
REQ-029 rst pulsed during REQ -> dmem_req drops immediately; after release IDLE, no spurious valid_out.

Source files
------------

// File: rtl/mem_stage.sv
// Memory access stage: decodes size/alignment, runs a single-outstanding data
// memory handshake, and aligns store data and load results to the 64-bit bus.
module mem_stage #(
    parameter int REG_WIDTH    = 64,
    parameter int REG_COUNT    = 32,
    parameter int WB_Ctrl_bits = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    // EX/MEM side
    input  logic                         valid_in,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [2:0]                   funct3,
    input  logic [REG_WIDTH-1:0]         ALU_res_in,
    input  logic [REG_WIDTH-1:0]         store_data,
    input  logic [$clog2(REG_COUNT)-1:0] rd_addr_in,
    input  logic [WB_Ctrl_bits-1:0]      WB_Ctrl_in,
    // data memory
    output logic                         dmem_req,
    output logic                         dmem_we,
    output logic [REG_WIDTH-1:0]         dmem_addr,
    output logic [63:0]                  dmem_wdata,
    output logic [7:0]                   dmem_wstrb,
    input  logic                         dmem_ready,
    input  logic [63:0]                  dmem_rdata,
    // MEM/WB side
    output logic                         valid_out,
    output logic [WB_Ctrl_bits-1:0]      WB_Ctrl_out,
    output logic [REG_WIDTH-1:0]         mem_read_data_out,
    output logic [REG_WIDTH-1:0]         ALU_res_out,
    output logic [$clog2(REG_COUNT)-1:0] rd_addr_out,
    output logic                         mem_exc,
    output logic                         stall_out
);

    localparam int RD_W = $clog2(REG_COUNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Byte-lane pattern of an access of the given size, starting at lane 0.
    function automatic logic [7:0] size_strb(input logic [2:0] f3);
        logic [7:0] s;
        case (f3)
            3'b000, 3'b100: s = 8'h01;
            3'b001, 3'b101: s = 8'h03;
            3'b010, 3'b110: s = 8'h0F;
            3'b011:         s = 8'hFF;
            default:        s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic is_fault(input logic rd_op, input logic wr_op,
                                      input logic [2:0] f3, input logic [2:0] off);
        logic f;
        case (f3)
            3'b000, 3'b100: f = 1'b0;
            3'b001, 3'b101: f = off[0];
            3'b010, 3'b110: f = |off[1:0];
            3'b011:         f = |off;
            default:        f = 1'b1;
        endcase
        return f | (rd_op & wr_op);
    endfunction

    function automatic logic [63:0] byte_mask(input logic [7:0] strb);
        logic [63:0] m;
        m = 64'h0;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    // raw is already shifted so the addressed byte sits in lane 0.
    function automatic logic [63:0] load_extend(input logic [2:0] f3, input logic [63:0] raw);
        logic [63:0] v;
        case (f3)
            3'b000:  v = {{56{raw[7]}},  raw[7:0]};
            3'b001:  v = {{48{raw[15]}}, raw[15:0]};
            3'b010:  v = {{32{raw[31]}}, raw[31:0]};
            3'b011:  v = raw;
            3'b100:  v = {56'h0, raw[7:0]};
            3'b101:  v = {48'h0, raw[15:0]};
            3'b110:  v = {32'h0, raw[31:0]};
            default: v = 64'h0;
        endcase
        return v;
    endfunction

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_is_load;
    logic                     r_is_store;
    logic [2:0]               r_funct3;
    logic [REG_WIDTH-1:0]     r_addr;
    logic [REG_WIDTH-1:0]     r_store_data;
    logic [RD_W-1:0]          r_rd;
    logic [WB_Ctrl_bits-1:0]  r_wb_ctrl;
    logic [63:0]              r_load_data;

    logic                     w_mem_op;
    logic                     w_fault;
    logic                     w_accept;
    logic [2:0]               w_off;
    logic [7:0]               w_strb;
    logic [63:0]              w_wdata;
    logic [63:0]              w_load_ext;

    assign w_mem_op   = mem_read | mem_write;
    assign w_fault    = is_fault(mem_read, mem_write, funct3, ALU_res_in[2:0]);
    assign w_accept   = (r_state == S_IDLE) && valid_in && w_mem_op && !w_fault && !rst;
    assign w_off      = r_addr[2:0];
    assign w_strb     = size_strb(r_funct3) << w_off;
    assign w_wdata    = (64'(r_store_data) & byte_mask(size_strb(r_funct3))) << {w_off, 3'b000};
    assign w_load_ext = load_extend(r_funct3, dmem_rdata >> {w_off, 3'b000});

    // State register, request latches and load-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_wb_ctrl    <= '0;
            r_load_data  <= 64'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_load    <= mem_read;
                r_is_store   <= mem_write;
                r_funct3     <= funct3;
                r_addr       <= ALU_res_in;
                r_store_data <= store_data;
                r_rd         <= rd_addr_in;
                r_wb_ctrl    <= WB_Ctrl_in;
            end
            if ((r_state == S_REQ) && dmem_ready && r_is_load) begin
                r_load_data <= w_load_ext;
            end
        end
    end

    // Next-state and all stage outputs; reset holds every output quiet.
    always_comb begin
        w_next            = r_state;
        valid_out         = 1'b0;
        WB_Ctrl_out       = '0;
        mem_read_data_out = '0;
        ALU_res_out       = '0;
        rd_addr_out       = '0;
        mem_exc           = 1'b0;
        stall_out         = 1'b0;
        dmem_req          = 1'b0;
        dmem_we           = 1'b0;
        dmem_addr         = '0;
        dmem_wdata        = 64'h0;
        dmem_wstrb        = 8'h00;
        if (rst) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!valid_in) begin
                        w_next = S_IDLE;
                    end else if (!w_mem_op) begin
                        valid_out   = 1'b1;
                        WB_Ctrl_out = WB_Ctrl_in;
                        ALU_res_out = ALU_res_in;
                        rd_addr_out = rd_addr_in;
                    end else if (w_fault) begin
                        // Exception squashes writeback; address kept for the trap handler.
                        valid_out   = 1'b1;
                        mem_exc     = 1'b1;
                        ALU_res_out = ALU_res_in;
                        rd_addr_out = rd_addr_in;
                    end else begin
                        stall_out = 1'b1;
                        w_next    = S_REQ;
                    end
                end
                S_REQ: begin
                    dmem_req   = 1'b1;
                    stall_out  = 1'b1;
                    dmem_we    = r_is_store;
                    dmem_addr  = {r_addr[REG_WIDTH-1:3], 3'b000};
                    if (r_is_store) begin
                        dmem_wstrb = w_strb;
                        dmem_wdata = w_wdata;
                    end else begin
                        dmem_wstrb = 8'h00;
                        dmem_wdata = 64'h0;
                    end
                    if (dmem_ready) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_REQ;
                    end
                end
                S_DONE: begin
                    valid_out   = 1'b1;
                    WB_Ctrl_out = r_wb_ctrl;
                    ALU_res_out = r_addr;
                    rd_addr_out = r_rd;
                    if (r_is_load) begin
                        mem_read_data_out = REG_WIDTH'(r_load_data);
                    end else begin
                        mem_read_data_out = '0;
                    end
                    w_next = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

endmodule
